// File: rtl/rf_pkg.sv
// Shared constants and clear-sequencer state encoding for the parametrised register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_ADDR_W = 4;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

endpackage

// File: rtl/reg_file_param_if.sv
// Decode/writeback-facing bus of the register file: two read ports, one write port, clear control.
interface reg_file_param_if #(
    parameter int unsigned DATA_W = rf_pkg::RF_DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::RF_ADDR_W
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data1, rd_data2, clr_busy, clr_done
    );

    modport slave (
        input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
        output rd_data1, rd_data2, clr_busy, clr_done
    );

endinterface

// File: rtl/rf_clear_fsm.sv
// Background clear sequencer: walks every entry once, issuing one zero-write per cycle.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [1:0]        S_IDLE   = RF_IDLE;
    localparam logic [1:0]        S_CLEAR  = RF_CLEAR;
    localparam logic [1:0]        S_DONE   = RF_DONE;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Busy and done are registered alongside the state so they line up with it exactly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req_i) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = idx_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports, write-first bypass,
// optional hardwired-zero entry 0 and a background clear sequencer.
module reg_file_param
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_param_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    logic              clr_busy;
    logic              clr_done;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc_c;

    rf_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req_i  (bus.clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Port writes are locked out while clearing; a hardwired r0 never accepts a write.
    assign wr_acc_c = bus.wr_en && !clr_busy && !(ZERO_REG && (bus.wr_addr == '0));

    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] mem_val,
        input logic              wr_acc,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] val;
        val = mem_val;
        if (wr_acc && (wr_addr == addr)) begin
            val = wr_data;
        end
        if (ZERO_REG && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_acc_c) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (bus.rd_en) begin
            rd1_d = read_sel(bus.rd_addr1, mem_q[bus.rd_addr1], wr_acc_c, bus.wr_addr, bus.wr_data);
            rd2_d = read_sel(bus.rd_addr2, mem_q[bus.rd_addr2], wr_acc_c, bus.wr_addr, bus.wr_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign bus.rd_data1 = rd1_q;
    assign bus.rd_data2 = rd2_q;
    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: drives a ZERO_REG=0 and a ZERO_REG=1 instance with identical stimulus.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        clr_req;

    always #5 clk = ~clk;

    reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) if1 ();

    assign if0.rd_en = rd_en;       assign if1.rd_en = rd_en;
    assign if0.rd_addr1 = rd_addr1; assign if1.rd_addr1 = rd_addr1;
    assign if0.rd_addr2 = rd_addr2; assign if1.rd_addr2 = rd_addr2;
    assign if0.wr_en = wr_en;       assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr;   assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;   assign if1.wr_data = wr_data;
    assign if0.clr_req = clr_req;   assign if1.clr_req = clr_req;

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    typedef struct {
        logic [15:0] r10, r20, r11, r21;
        logic        busy, done;
    } exp_t;

    typedef struct {
        logic        re;
        logic [3:0]  a1, a2;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        cr;
        logic        ck;
        logic [15:0] e1, ez;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        tbl[9];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    logic [15:0] m0[16];
    logic [15:0] m1[16];
    logic [15:0] r10, r20, r11, r21;
    int          mst, midx;
    logic        mbusy, mdone;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m0[i] = 16'h0;
            m1[i] = 16'h0;
        end
        r10 = 16'h0; r20 = 16'h0; r11 = 16'h0; r21 = 16'h0;
        mst = 0; midx = 0; mbusy = 1'b0; mdone = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one edge, push its prediction, then check the DUTs after the edge.
    task automatic step();
        exp_t e;
        logic wok0, wok1;
        wok0 = wr_en && !mbusy;
        wok1 = wok0 && (wr_addr != 4'd0);
        if (rd_en) begin
            r10 = (wok0 && wr_addr == rd_addr1) ? wr_data : m0[rd_addr1];
            r20 = (wok0 && wr_addr == rd_addr2) ? wr_data : m0[rd_addr2];
            r11 = (rd_addr1 == 4'd0) ? 16'h0 : (wok1 && wr_addr == rd_addr1) ? wr_data : m1[rd_addr1];
            r21 = (rd_addr2 == 4'd0) ? 16'h0 : (wok1 && wr_addr == rd_addr2) ? wr_data : m1[rd_addr2];
        end
        case (mst)
            0: if (clr_req) begin mst = 1; midx = 0; mbusy = 1'b1; end
            1: begin
                m0[midx] = 16'h0;
                m1[midx] = 16'h0;
                if (midx == 15) begin mst = 2; mbusy = 1'b0; mdone = 1'b1; end
                else midx++;
            end
            default: begin mst = 0; mdone = 1'b0; end
        endcase
        if (wok0) m0[wr_addr] = wr_data;
        if (wok1) m1[wr_addr] = wr_data;
        e.r10 = r10; e.r20 = r20; e.r11 = r11; e.r21 = r21;
        e.busy = mbusy; e.done = mdone;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 16'h1, 16'h0);
        end else begin
            e = exp_q.pop_front();
            chk("rd1_z0", if0.rd_data1, e.r10);
            chk("rd2_z0", if0.rd_data2, e.r20);
            chk("rd1_z1", if1.rd_data1, e.r11);
            chk("rd2_z1", if1.rd_data2, e.r21);
            chk("busy", {15'd0, if0.clr_busy}, {15'd0, e.busy});
            chk("done", {15'd0, if1.clr_done}, {15'd0, e.done});
        end
    endtask

    task automatic drive(input logic re, input logic [3:0] a1, input logic [3:0] a2,
                         input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic cr);
        rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
        wr_en = we; wr_addr = wa; wr_data = wd; clr_req = cr;
        step();
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0; clr_req = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, released away from the next rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_rd1_z0", if0.rd_data1, 16'h0);
        chk("rst_rd2_z0", if0.rd_data2, 16'h0);
        chk("rst_rd1_z1", if1.rd_data1, 16'h0);
        chk("rst_busy",   {15'd0, if0.clr_busy}, 16'h0);
        chk("rst_done",   {15'd0, if0.clr_done}, 16'h0);
        chk("rst_busy_z1", {15'd0, if1.clr_busy}, 16'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int busy_cnt, done_cnt;

    initial begin
        rst = 1'b1;
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h9999;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        //            re   a1     a2     we   wa     wd        cr   ck   e1        ez
        tbl[0] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'h1234};
        tbl[2] = '{1'b1, 4'd5, 4'd3, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF};
        tbl[3] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{1'b1, 4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000};
        tbl[5] = '{1'b0, 4'd3, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000};
        tbl[6] = '{1'b0, 4'd5, 4'd9, 1'b1, 4'd9, 16'h4242, 1'b0, 1'b1, 16'hFFFF, 16'h0000};
        tbl[7] = '{1'b1, 4'd0, 4'd9, 1'b1, 4'd0, 16'h7777, 1'b0, 1'b1, 16'h7777, 16'h0000};
        tbl[8] = '{1'b1, 4'd9, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h4242, 16'h4242};

        foreach (tbl[i]) begin
            drive(tbl[i].re, tbl[i].a1, tbl[i].a2, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].cr);
            if (tbl[i].ck) begin
                chk($sformatf("vec%0d_rd1_z0", i), if0.rd_data1, tbl[i].e1);
                chk($sformatf("vec%0d_rd1_z1", i), if1.rd_data1, tbl[i].ez);
            end
        end

        // Fill, then clear; a write during the sweep and repeat requests must be ignored.
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 4'd0, 1'b1, 4'(i), 16'hA5A5, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1);
        busy_cnt += int'(if0.clr_busy); done_cnt += int'(if0.clr_done);
        for (int k = 0; k < 22; k++) begin
            drive(1'b1, 4'(k), 4'(15 - (k % 16)), k == 10, 4'd7, 16'h1111, (k == 3) || (k == 16));
            busy_cnt += int'(if0.clr_busy); done_cnt += int'(if0.clr_done);
        end
        chk("clr_busy_cycles", 16'(busy_cnt), 16'd16);
        chk("clr_done_pulses", 16'(done_cnt), 16'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 4'(i), 1'b0, 4'd0, 16'h0, 1'b0);
            chk($sformatf("cleared_r%0d", i), if0.rd_data1, 16'h0);
        end

        // Reset in the middle of a clear sweep.
        drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 16'h2222, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd12, 16'hCCCC, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1);
        for (int k = 0; k < 5; k++) drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0);
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 4'(15 - i), 1'b0, 4'd0, 16'h0, 1'b0);
            done_cnt += int'(if0.clr_done);
            chk($sformatf("post_rst_r%0d", i), if0.rd_data1, 16'h0);
        end
        chk("no_done_after_rst", 16'(done_cnt), 16'd0);

        // Restart begins at entry 0 and again takes exactly 16 busy cycles.
        drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 16'h3333, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 16'h4444, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1);
        busy_cnt += int'(if0.clr_busy);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0);
        busy_cnt += int'(if0.clr_busy);
        drive(1'b1, 4'd0, 4'd15, 1'b0, 4'd0, 16'h0, 1'b0);
        busy_cnt += int'(if0.clr_busy);
        chk("restart_r0_cleared", if0.rd_data1, 16'h0);
        chk("restart_r15_live",   if0.rd_data2, 16'h4444);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0);
            busy_cnt += int'(if0.clr_busy); done_cnt += int'(if0.clr_done);
        end
        chk("restart_busy_cycles", 16'(busy_cnt), 16'd16);
        chk("restart_done_pulses", 16'(done_cnt), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
